// File: rtl/aes_pkg.sv
// Shared types, round counts and helpers for the AES round controller.
package aes_pkg;

  typedef enum logic [1:0] {
    AES128 = 2'b00,
    AES192 = 2'b01,
    AES256 = 2'b10
  } aes_mode_t;

  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARK0,
    ST_KWAIT,
    ST_ROUND,
    ST_DONE
  } aes_ctrl_state_t;

  // Encoding 11 has no AES meaning; it runs as AES256.
  function automatic logic [3:0] nr_of(input logic [1:0] mode);
    case (mode)
      AES128:  nr_of = 4'(NR_128);
      AES192:  nr_of = 4'(NR_192);
      default: nr_of = 4'(NR_256);
    endcase
  endfunction

endpackage

// File: rtl/aes_subround_cnt.sv
// Sub-round slot counter: counts 0..ROUND_CYCLES-1 while enabled, flags the last slot.
module aes_subround_cnt #(
  parameter int ROUND_CYCLES = 17,
  parameter int RCNT_W       = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  output logic [RCNT_W-1:0] cnt,
  output logic              tc
);

  localparam logic [RCNT_W-1:0] TC_VAL = RCNT_W'(ROUND_CYCLES - 1);

  logic [RCNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == TC_VAL) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == TC_VAL);

endmodule

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the byte-serial AES datapath; owns the 128-bit state register.
// Defining AES_ROUND_CTRL_ABORT_EN adds an abort input that drops any block in flight.
//   state | meaning
//   IDLE  | waiting for a block, in_ready high
//   ARK0  | round-0 AddRoundKey, waits for round key 0
//   KWAIT | first slot of rounds 2..Nr; holds at slot 0 until the key is ready
//   ROUND | byte slots plus drain slot, state captured on the last one
//   DONE  | result held on out_data until out_ready
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int ROUND_CYCLES = 17,
  parameter int RCNT_W       = 5
) (
  input  logic         clk,
  input  logic         reset,
`ifdef AES_ROUND_CTRL_ABORT_EN
  input  logic         abort,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_mode,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  input  logic         rk_valid,
  output logic [3:0]   round,
  output logic [1:0]   dp_mode,
  output logic [3:0]   dp_width_sel,
  output logic [127:0] dp_data_in,
  input  logic [127:0] dp_data_out,
  output logic         busy
);

  aes_ctrl_state_t   fsm_q, fsm_d;
  logic [3:0]        round_q, round_d;
  logic [1:0]        mode_q, mode_d;
  logic [127:0]      state_q, state_d;
  logic              cnt_clr, cnt_en, cnt_tc;
  logic [RCNT_W-1:0] sub_cnt;
  logic              abort_w;

`ifdef AES_ROUND_CTRL_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  aes_subround_cnt #(
    .ROUND_CYCLES(ROUND_CYCLES),
    .RCNT_W      (RCNT_W)
  ) u_subround_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .cnt  (sub_cnt),
    .tc   (cnt_tc)
  );

  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    mode_d  = mode_q;
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;

    case (fsm_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = in_data;
          mode_d  = in_mode;
          round_d = 4'd0;
          cnt_clr = 1'b1;
          fsm_d   = ST_ARK0;
        end
      end
      ST_ARK0: begin
        if (rk_valid) begin
          state_d = dp_data_out;
          round_d = 4'd1;
          cnt_clr = 1'b1;
          fsm_d   = ST_ROUND;
        end
      end
      // A ready key makes this cycle slot 0 of the round, so no bubble is added.
      ST_KWAIT: begin
        if (rk_valid) begin
          cnt_en = 1'b1;
          fsm_d  = ST_ROUND;
        end
      end
      ST_ROUND: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          state_d = dp_data_out;
          if (round_q == nr_of(mode_q)) begin
            fsm_d = ST_DONE;
          end else begin
            round_d = round_q + 4'd1;
            fsm_d   = ST_KWAIT;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          round_d = 4'd0;
          fsm_d   = ST_IDLE;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase

    if (abort_w && (fsm_q != ST_IDLE)) begin
      fsm_d   = ST_IDLE;
      state_d = '0;
      round_d = 4'd0;
      cnt_clr = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q   <= ST_IDLE;
      round_q <= 4'd0;
      mode_q  <= 2'b00;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      mode_q  <= mode_d;
      state_q <= state_d;
    end
  end

  assign in_ready     = (fsm_q == ST_IDLE);
  assign out_valid    = (fsm_q == ST_DONE);
  assign busy         = (fsm_q != ST_IDLE);
  assign round        = round_q;
  assign dp_mode      = mode_q;
  assign dp_data_in   = state_q;
  assign out_data     = state_q;
  // Drain slot (and any slot past 15) selects byte 0.
  assign dp_width_sel = (sub_cnt > RCNT_W'(15)) ? 4'd0 : sub_cnt[3:0];

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: behavioural AES round datapath and key schedule,
// FIPS-197 vectors, key stalls, backpressure, random blocks and optional abort.
module tb_aes_round_ctrl;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid, in_ready, out_valid, out_ready, rk_valid, busy;
  logic [1:0]   in_mode, dp_mode;
  logic [127:0] in_data, out_data, dp_data_in, dp_data_out;
  logic [3:0]   round, dp_width_sel;
`ifdef AES_ROUND_CTRL_ABORT_EN
  logic         abort = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] rk_tab [16];
  int           tb_nr = 10;

  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY_SEQ =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  aes_round_ctrl dut (
    .clk         (clk),
    .reset       (reset),
`ifdef AES_ROUND_CTRL_ABORT_EN
    .abort       (abort),
`endif
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_mode     (in_mode),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .rk_valid    (rk_valid),
    .round       (round),
    .dp_mode     (dp_mode),
    .dp_width_sel(dp_width_sel),
    .dp_data_in  (dp_data_in),
    .dp_data_out (dp_data_out),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- AES reference arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
    logic [15:0] d = {v, v};
    return d[15-k -: 8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o = '0;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3,
                           a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3,
                           a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3),
                           gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2)};
    end
    return o;
  endfunction

  function automatic logic [127:0] aes_rnd(input logic [127:0] s, input logic [127:0] k,
                                           input bit first, input bit last);
    logic [127:0] t;
    if (first) return s ^ k;
    t = sub_shift(s);
    if (!last) t = mix(t);
    return t ^ k;
  endfunction

  task automatic load_keys(input logic [255:0] key, input logic [1:0] mode);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    int nk;
    nk    = (mode == 2'b00) ? 4 : (mode == 2'b01) ? 6 : 8;
    tb_nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (tb_nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      if (r <= tb_nr) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else            rk_tab[r] = '0;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk_tab[0];
    for (int r = 1; r <= tb_nr; r++) s = aes_rnd(s, rk_tab[r], 1'b0, r == tb_nr);
    return s;
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Datapath stand-in: full AES round on the presented state using the key for `round`.
  assign dp_data_out = aes_rnd(dp_data_in, rk_tab[round], round == 4'd0, int'(round) == tb_nr);

  // ---------------- stimulus helpers ----------------
  task automatic start_block(input logic [255:0] key, input logic [1:0] mode,
                             input logic [127:0] pt);
    int t = 0;
    load_keys(key, mode);
    rk_valid = 1'b1;
    in_valid = 1'b1;
    in_mode  = mode;
    in_data  = pt;
    while (in_ready !== 1'b1 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_mode  = 2'($urandom);
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    n_checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1 || round !== 4'd0 || dp_mode !== mode) begin
      n_fail++;
      $display("FAIL accept: in_ready=%b busy=%b round=%0d dp_mode=%0d required 0 1 0 %0d",
               in_ready, busy, round, dp_mode, mode);
    end
  endtask

  task automatic wait_round(input int r);
    int t = 0;
    while (int'(round) != r && t < 400) begin
      @(posedge clk); #1; t++;
    end
    n_checks++;
    if (int'(round) != r) begin
      n_fail++;
      $display("FAIL wait_round: round=%0d required %0d", round, r);
    end
  endtask

  task automatic run_block(input logic [255:0] key, input logic [1:0] mode,
                           input logic [127:0] pt, input int stall_rnd, input int stall_len,
                           input bit jitter, output int lat, output logic [127:0] res);
    int last_rnd = 0;
    bit stalled  = 1'b0;
    start_block(key, mode, pt);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 1000) begin
      if (int'(round) != last_rnd) begin
        n_checks++;
        if (int'(round) != last_rnd + 1) begin
          n_fail++;
          $display("FAIL round_seq: round=%0d required %0d", round, last_rnd + 1);
        end
        last_rnd = int'(round);
      end
      if (!stalled && stall_len > 0 && int'(round) == stall_rnd) begin
        stalled  = 1'b1;
        rk_valid = 1'b0;
        for (int i = 0; i < stall_len; i++) begin
          @(posedge clk); #1; lat++;
          n_checks++;
          if (dp_width_sel !== 4'd0 || int'(round) != stall_rnd || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL key_stall: width_sel=%0d round=%0d out_valid=%b required 0 %0d 0",
                     dp_width_sel, round, out_valid, stall_rnd);
          end
        end
        rk_valid = 1'b1;
      end else begin
        // Key valid may wobble only on mid-round slots, where it must be ignored.
        rk_valid = (jitter && dp_width_sel >= 4'd1 && dp_width_sel <= 4'd14) ?
                   1'($urandom) : 1'b1;
        @(posedge clk); #1; lat++;
      end
    end
    rk_valid = 1'b1;
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL done_timeout: out_valid=%b required 1", out_valid);
    end
    n_checks++;
    if (last_rnd != tb_nr) begin
      n_fail++;
      $display("FAIL final_round: last round=%0d required %0d", last_rnd, tb_nr);
    end
    res = out_data;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || round !== 4'd0 ||
        dp_width_sel !== 4'd0 || dp_mode !== 2'b00 || out_data !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_values: busy=%b in_ready=%b out_valid=%b round=%0d wsel=%0d mode=%0d data=%h",
               busy, in_ready, out_valid, round, dp_width_sel, dp_mode, out_data);
    end
    reset = 1'b0;
    start_block(rand256(), 2'b10, PT);
    wait_round(5);
    repeat (6) begin @(posedge clk); #1; end
    n_checks++;
    if (dp_width_sel === 4'd0 || round !== 4'd5) begin
      n_fail++;
      $display("FAIL reset_setup: wsel=%0d round=%0d required nonzero 5", dp_width_sel, round);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || round !== 4'd0 ||
        dp_width_sel !== 4'd0 || out_data !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_midrun: busy=%b in_ready=%b out_valid=%b round=%0d wsel=%0d data=%h",
               busy, in_ready, out_valid, round, dp_width_sel, out_data);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: busy=%b in_ready=%b required 0 1", busy, in_ready);
    end
  endtask

  task automatic test_fips;
    logic [127:0] exp_ct [3];
    logic [127:0] res;
    int lat;
    exp_ct[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    exp_ct[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    exp_ct[2] = 128'h8ea2b7ca516745bfeafc49904b496089;
    for (int m = 0; m < 3; m++) begin
      run_block(KEY_SEQ, 2'(m), PT, 0, 0, 1'b0, lat, res);
      n_checks++;
      if (res !== exp_ct[m]) begin
        n_fail++;
        $display("FAIL fips_data mode=%0d: got %h required %h", m, res, exp_ct[m]);
      end
      n_checks++;
      if (lat != 1 + 17 * (10 + 2 * m)) begin
        n_fail++;
        $display("FAIL fips_latency mode=%0d: got %0d required %0d", m, lat, 1 + 17 * (10 + 2 * m));
      end
      @(posedge clk); #1;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL fips_release: in_ready=%b out_valid=%b busy=%b required 1 0 0",
                 in_ready, out_valid, busy);
      end
    end
  endtask

  task automatic test_key_stall;
    logic [127:0] res;
    int lat;
    run_block(KEY_SEQ, 2'b00, PT, 3, 5, 1'b0, lat, res);
    n_checks++;
    if (res !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
      n_fail++;
      $display("FAIL stall_data: got %h required 69c4e0d86a7b0430d8cdb78070b4c55a", res);
    end
    n_checks++;
    if (lat != 176) begin
      n_fail++;
      $display("FAIL stall_latency: got %0d required 176", lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    logic [127:0] res, exp2;
    logic [255:0] k2;
    int lat;
    bit bad = 1'b0;
    out_ready = 1'b0;
    run_block(KEY_SEQ, 2'b00, PT, 0, 0, 1'b0, lat, res);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          out_data !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
        n_fail++; bad = 1'b1;
        $display("FAIL backpressure_hold cycle %0d: out_valid=%b in_ready=%b data=%h", i,
                 out_valid, in_ready, out_data);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b busy=%b required 0 1 0",
               out_valid, in_ready, busy);
    end
    k2 = rand256();
    run_block(k2, 2'b01, ~PT, 0, 0, 1'b0, lat, res);
    exp2 = aes_ref(~PT);
    n_checks++;
    if (res !== exp2) begin
      n_fail++;
      $display("FAIL backpressure_next: got %h required %h", res, exp2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [127:0] res, pt2, exp2;
    int lat;
    run_block(KEY_SEQ, 2'b10, PT, 0, 0, 1'b0, lat, res);
    pt2      = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1;
    in_data  = pt2;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_no_reaccept: in_ready=%b busy=%b required 1 0", in_ready, busy);
    end
    run_block(KEY_SEQ, 2'b10, pt2, 0, 0, 1'b0, lat, res);
    exp2 = aes_ref(pt2);
    n_checks++;
    if (res !== exp2 || lat != 239) begin
      n_fail++;
      $display("FAIL b2b_second: got %h lat %0d required %h lat 239", res, lat, exp2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    logic [255:0] key;
    logic [127:0] pt, res, exp_ct;
    logic [1:0]   mode;
    int lat, nr, s_rnd, s_len;
    for (int n = 0; n < 6; n++) begin
      key   = rand256();
      pt    = {$urandom, $urandom, $urandom, $urandom};
      mode  = 2'($urandom_range(0, 3));
      nr    = (mode == 2'b00) ? 10 : (mode == 2'b01) ? 12 : 14;
      s_len = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : 0;
      s_rnd = int'($urandom_range(2, nr));
      run_block(key, mode, pt, s_rnd, s_len, 1'b1, lat, res);
      exp_ct = aes_ref(pt);
      n_checks++;
      if (res !== exp_ct) begin
        n_fail++;
        $display("FAIL random_data #%0d mode=%0d: got %h required %h", n, mode, res, exp_ct);
      end
      n_checks++;
      if (lat != 1 + 17 * nr + s_len) begin
        n_fail++;
        $display("FAIL random_latency #%0d: got %0d required %0d", n, lat, 1 + 17 * nr + s_len);
      end
      @(posedge clk); #1;
    end
  endtask

`ifdef AES_ROUND_CTRL_ABORT_EN
  task automatic test_abort;
    logic [255:0] key;
    logic [127:0] res, exp_ct;
    int lat;
    bit saw = 1'b0;
    start_block(rand256(), 2'b10, PT);
    wait_round(7);
    repeat (4) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 128'h0 ||
        round !== 4'd0) begin
      n_fail++;
      $display("FAIL abort_idle: busy=%b in_ready=%b out_valid=%b round=%0d data=%h",
               busy, in_ready, out_valid, round, out_data);
    end
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) saw = 1'b1;
    end
    n_checks++;
    if (saw !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_output: out_valid seen=%b required 0", saw);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_in_idle: in_ready=%b busy=%b required 1 0", in_ready, busy);
    end
    key = rand256();
    run_block(key, 2'b00, PT, 0, 0, 1'b0, lat, res);
    exp_ct = aes_ref(PT);
    n_checks++;
    if (res !== exp_ct || lat != 171) begin
      n_fail++;
      $display("FAIL abort_next_block: got %h lat %0d required %h lat 171", res, lat, exp_ct);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    in_valid  = 1'b0;
    in_mode   = 2'b00;
    in_data   = '0;
    out_ready = 1'b1;
    rk_valid  = 1'b1;
    for (int r = 0; r < 16; r++) rk_tab[r] = '0;
    test_reset;
    test_fips;
    test_key_stall;
    test_backpressure;
    test_back_to_back;
    test_random;
`ifdef AES_ROUND_CTRL_ABORT_EN
    test_abort;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
